// File: rtl/mm_read_arbiter.sv
// ----------------------------------------------------------------------------
// mm_read_arbiter
//   Shares the single main-memory read port between requester 0 (I-cache)
//   and requester 1 (D-cache). One requester is granted at a time with
//   round-robin fairness; the granted address is held on MMAddress while
//   MMRead is high, the returned block is registered and the granted
//   requester gets a one-cycle DataReady pulse. A watchdog aborts reads that
//   memory never answers and raises a sticky Timeout flag.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   Req0/Addr0   requester 0 request (held until DataReady0) and block address
//   Req1/Addr1   requester 1 request (held until DataReady1) and block address
//   MMDataReady  main memory: MMData valid this cycle
//   MMData       main-memory read data
//   MMRead       read strobe to main memory
//   MMAddress    latched address of the granted requester
//   BlockOut     registered block, valid while DataReadyN=1
//   DataReady0/1 one-cycle completion pulses
//   Busy         high whenever the arbiter is not idle
//   Timeout      sticky watchdog error flag, cleared only by reset
// All outputs are driven straight from flops.
// ----------------------------------------------------------------------------
module mm_read_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BLOCK_WIDTH    = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Req0,
    input  logic [ADDR_WIDTH-1:0]  Addr0,
    input  logic                   Req1,
    input  logic [ADDR_WIDTH-1:0]  Addr1,
    input  logic                   MMDataReady,
    input  logic [BLOCK_WIDTH-1:0] MMData,
    output logic                   MMRead,
    output logic [ADDR_WIDTH-1:0]  MMAddress,
    output logic [BLOCK_WIDTH-1:0] BlockOut,
    output logic                   DataReady0,
    output logic                   DataReady1,
    output logic                   Busy,
    output logic                   Timeout
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state_q,   state_d;
    logic                   grant_q,   grant_d;
    logic                   rr_q,      rr_d;
    logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
    logic [BLOCK_WIDTH-1:0] block_q,   block_d;
    logic                   timeout_q, timeout_d;
    logic                   mmread_q,  mmread_d;
    logic                   dr0_q,     dr0_d;
    logic                   dr1_q,     dr1_d;
    logic                   busy_q,    busy_d;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        block_d   = block_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (Req0 || Req1) begin
                    // Contention goes to the favoured side; otherwise the lone requester.
                    grant_d = (Req0 && Req1) ? rr_q : Req1;
                    addr_d  = grant_d ? Addr1 : Addr0;
                    cnt_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + 1'b1;
                // Data beats the watchdog when both land on the same edge.
                if (MMDataReady) begin
                    block_d = MMData;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DONE: begin
                rr_d    = ~grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from next state so they leave flops glitch-free.
        mmread_d = (state_d == S_READ);
        dr0_d    = (state_d == S_DONE) && !grant_d;
        dr1_d    = (state_d == S_DONE) &&  grant_d;
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            block_q   <= '0;
            timeout_q <= 1'b0;
            mmread_q  <= 1'b0;
            dr0_q     <= 1'b0;
            dr1_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            block_q   <= block_d;
            timeout_q <= timeout_d;
            mmread_q  <= mmread_d;
            dr0_q     <= dr0_d;
            dr1_q     <= dr1_d;
            busy_q    <= busy_d;
        end
    end

    assign MMRead     = mmread_q;
    assign MMAddress  = addr_q;
    assign BlockOut   = block_q;
    assign DataReady0 = dr0_q;
    assign DataReady1 = dr1_q;
    assign Busy       = busy_q;
    assign Timeout    = timeout_q;

endmodule

// File: tb/tb_mm_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mm_read_arbiter
//   Directed sequence plus randomized transactions against a transaction-level
//   reference: round-robin favour, last delivered block and sticky timeout are
//   tracked as plain variables and every DUT output is compared each cycle.
// ----------------------------------------------------------------------------
module tb_mm_read_arbiter;

    localparam int AW = 32;
    localparam int BW = 128;
    localparam int TO = 64;

    logic          clk;
    logic          rst;
    logic          Req0, Req1;
    logic [AW-1:0] Addr0, Addr1;
    logic          MMDataReady;
    logic [BW-1:0] MMData;
    logic          MMRead;
    logic [AW-1:0] MMAddress;
    logic [BW-1:0] BlockOut;
    logic          DataReady0, DataReady1;
    logic          Busy, Timeout;

    int checks = 0;
    int errors = 0;

    // Reference state
    int            m_rr;       // requester favoured on contention
    logic [BW-1:0] m_block;    // last block delivered
    logic          m_timeout;  // sticky error flag

    mm_read_arbiter #(
        .ADDR_WIDTH     (AW),
        .BLOCK_WIDTH    (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Req0        (Req0),
        .Addr0       (Addr0),
        .Req1        (Req1),
        .Addr1       (Addr1),
        .MMDataReady (MMDataReady),
        .MMData      (MMData),
        .MMRead      (MMRead),
        .MMAddress   (MMAddress),
        .BlockOut    (BlockOut),
        .DataReady0  (DataReady0),
        .DataReady1  (DataReady1),
        .Busy        (Busy),
        .Timeout     (Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_mmread"}, MMRead, 1'b0);
        chk({tag, "_busy"}, Busy, 1'b0);
        chk({tag, "_dr0"}, DataReady0, 1'b0);
        chk({tag, "_dr1"}, DataReady1, 1'b0);
        chk({tag, "_block"}, BlockOut, m_block);
        chk({tag, "_timeout"}, Timeout, m_timeout);
    endtask

    // One complete transaction from the current request pattern; memory
    // answers after lat extra READ cycles. Ends one cycle into IDLE.
    task automatic serve(input string tag, input int lat);
        int            g;
        logic [AW-1:0] exp_addr;
        logic [BW-1:0] data;
        g        = (Req0 && Req1) ? m_rr : (Req1 ? 1 : 0);
        exp_addr = (g == 1) ? Addr1 : Addr0;
        data     = rand_block();
        step();
        chk({tag, "_read_mmread"}, MMRead, 1'b1);
        chk({tag, "_read_busy"}, Busy, 1'b1);
        chk({tag, "_read_addr"}, MMAddress, exp_addr);
        Addr0 = $urandom;
        Addr1 = $urandom;
        for (int i = 0; i < lat; i++) begin
            step();
            chk({tag, "_wait_mmread"}, MMRead, 1'b1);
            chk({tag, "_wait_dr"}, {DataReady1, DataReady0}, 2'b00);
            chk({tag, "_wait_addr"}, MMAddress, exp_addr);
        end
        MMDataReady = 1'b1;
        MMData      = data;
        step();
        MMDataReady = 1'b0;
        MMData      = rand_block();
        m_block     = data;
        m_rr        = 1 - g;
        chk({tag, "_done_dr0"}, DataReady0, (g == 0));
        chk({tag, "_done_dr1"}, DataReady1, (g == 1));
        chk({tag, "_done_block"}, BlockOut, data);
        chk({tag, "_done_mmread"}, MMRead, 1'b0);
        chk({tag, "_done_busy"}, Busy, 1'b1);
        chk({tag, "_done_timeout"}, Timeout, m_timeout);
        if (g == 0) Req0 = 1'b0;
        else        Req1 = 1'b0;
        step();
        chk({tag, "_post_mmread"}, MMRead, 1'b0);
        chk({tag, "_post_busy"}, Busy, 1'b0);
        chk({tag, "_post_dr"}, {DataReady1, DataReady0}, 2'b00);
        chk({tag, "_post_block"}, BlockOut, m_block);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        Req0        = 1'b0;
        Req1        = 1'b0;
        MMDataReady = 1'b0;
        m_rr        = 0;
        m_block     = '0;
        m_timeout   = 1'b0;
        #1;
        chk("rst_addr", MMAddress, '0);
        chk_idle("rst");
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_rel_addr", MMAddress, '0);
        chk_idle("rst_rel");
    endtask

    initial begin
        Addr0  = '0;
        Addr1  = '0;
        MMData = '0;

        do_reset();

        // Single request, fixed address and pattern
        Req0  = 1'b1;
        Addr0 = 32'h40;
        Req1  = 1'b0;
        begin
            logic [BW-1:0] pat;
            pat = {16{8'hA5}};
            step();
            chk("t1_mmread", MMRead, 1'b1);
            chk("t1_addr", MMAddress, 32'h40);
            for (int i = 0; i < 3; i++) begin
                step();
                chk("t1_wait_dr", {DataReady1, DataReady0}, 2'b00);
            end
            MMDataReady = 1'b1;
            MMData      = pat;
            step();
            MMDataReady = 1'b0;
            m_block     = pat;
            m_rr        = 1;
            chk("t1_dr0", DataReady0, 1'b1);
            chk("t1_dr1", DataReady1, 1'b0);
            chk("t1_block", BlockOut, pat);
            Req0 = 1'b0;
            step();
            chk_idle("t1_after");
        end

        // Both held from reset: alternation 0,1,0,1
        do_reset();
        for (int t = 0; t < 4; t++) begin
            Req0  = 1'b1;
            Req1  = 1'b1;
            Addr0 = $urandom;
            Addr1 = $urandom;
            serve("t2", $urandom_range(0, 4));
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        step();
        chk_idle("t2_end");

        // Stray MMDataReady while idle
        for (int i = 0; i < 6; i++) begin
            MMDataReady = $urandom_range(0, 1);
            MMData      = rand_block();
            step();
            chk_idle("t6");
        end
        MMDataReady = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            Req0 = Req0 | 1'($urandom_range(0, 1));
            Req1 = Req1 | 1'($urandom_range(0, 1));
            if (!Req0 && !Req1) Req0 = 1'b1;
            Addr0 = $urandom;
            Addr1 = $urandom;
            serve("rnd", $urandom_range(0, 12));
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        step();
        chk_idle("rnd_end");

        // Data arriving on the last READ cycle beats the watchdog
        Req1  = 1'b1;
        Addr1 = $urandom;
        serve("t4", TO - 1);
        chk("t4_timeout", Timeout, 1'b0);

        // Memory never answers
        Req1  = 1'b1;
        Addr1 = $urandom;
        begin
            logic [AW-1:0] a;
            a = Addr1;
            step();
            chk("t3_mmread_first", MMRead, 1'b1);
            chk("t3_addr", MMAddress, a);
            for (int i = 1; i < TO; i++) begin
                step();
                chk("t3_mmread_hold", MMRead, 1'b1);
                chk("t3_no_timeout_yet", Timeout, 1'b0);
                chk("t3_dr_hold", {DataReady1, DataReady0}, 2'b00);
            end
            step();
            Req1      = 1'b0;
            m_timeout = 1'b1;
            chk_idle("t3_abort");
            for (int i = 0; i < 3; i++) begin
                step();
                chk_idle("t3_sticky");
            end
        end
        Req0  = 1'b1;
        Addr0 = $urandom;
        serve("t3_next", 2);
        chk("t3_timeout_kept", Timeout, 1'b1);

        // Asynchronous reset in the middle of a read
        Req0  = 1'b1;
        Req1  = 1'b1;
        Addr0 = $urandom;
        Addr1 = $urandom;
        step();
        chk("t5_mmread", MMRead, 1'b1);
        step();
        step();
        #2;
        rst         = 1'b0;
        Req0        = 1'b0;
        Req1        = 1'b0;
        MMDataReady = 1'b1;
        MMData      = rand_block();
        m_rr        = 0;
        m_block     = '0;
        m_timeout   = 1'b0;
        #1;
        chk("t5_async_addr", MMAddress, '0);
        chk_idle("t5_async");
        step();
        step();
        MMDataReady = 1'b0;
        rst         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("t5_release");
        end
        Req0  = 1'b1;
        Req1  = 1'b1;
        Addr0 = $urandom;
        Addr1 = $urandom;
        serve("t5_first", 1);
        Req0 = 1'b1;
        serve("t5_second", 1);
        Req0 = 1'b0;
        Req1 = 1'b0;

        // A request dropped mid-read still completes
        Req0  = 1'b1;
        Addr0 = $urandom;
        begin
            logic [AW-1:0] a;
            logic [BW-1:0] d;
            a = Addr0;
            d = rand_block();
            step();
            Req0 = 1'b0;
            chk("drop_addr", MMAddress, a);
            step();
            chk("drop_mmread", MMRead, 1'b1);
            MMDataReady = 1'b1;
            MMData      = d;
            step();
            MMDataReady = 1'b0;
            m_block     = d;
            m_rr        = 1;
            chk("drop_dr0", DataReady0, 1'b1);
            chk("drop_block", BlockOut, d);
            step();
            chk_idle("drop_end");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
